// File: rtl/palette_pkg.sv
// Shared definitions for the palette lookup arbiter: default widths, requester IDs,
// round-robin state encoding and the backdrop mirror mask.
package palette_pkg;

    localparam int unsigned AW_DEF = 5;
    localparam int unsigned DW_DEF = 8;
    localparam int unsigned CW_DEF = 6;

    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    // Sprite backdrop entries fold onto the background backdrop through this mask.
    localparam logic [7:0] MIRROR_MASK = 8'h0F;

    typedef enum logic {
        REQ_BG  = 1'b0,
        REQ_SPR = 1'b1
    } req_id_e;

    typedef enum logic {
        LAST_BG  = 1'b0,
        LAST_SPR = 1'b1
    } rr_state_e;

endpackage : palette_pkg

// File: rtl/pal_rr_arb2.sv
// Two-way round-robin arbiter between the background and sprite lookup requests.
// Grants are combinational; the state remembers who was granted last.
module pal_rr_arb2
    import palette_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic req_bg_i,
    input  logic req_spr_i,
    output logic gnt_bg_c,
    output logic gnt_spr_c
);

    rr_state_e state_q;
    logic      active;

    // No grants while disabled or while reset is held.
    assign active = en_i & ~rst;

    always_comb begin
        gnt_bg_c  = 1'b0;
        gnt_spr_c = 1'b0;
        if (active) begin
            if (req_bg_i && req_spr_i) begin
                gnt_bg_c  = (state_q == LAST_SPR);
                gnt_spr_c = (state_q == LAST_BG);
            end else begin
                gnt_bg_c  = req_bg_i;
                gnt_spr_c = req_spr_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LAST_SPR;
        end else if (gnt_bg_c) begin
            state_q <= LAST_BG;
        end else if (gnt_spr_c) begin
            state_q <= LAST_SPR;
        end
    end

endmodule : pal_rr_arb2

// File: rtl/palette_arbiter.sv
// Palette lookup arbiter: shares one clocked palette memory between background and
// sprite pipelines. Optional backdrop mirroring is enabled by defining PALETTE_MIRROR_EN.
module palette_arbiter
    import palette_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          render_en,
    input  logic          bg_req,
    input  logic [AW-1:0] bg_addr,
    output logic          bg_gnt,
    input  logic          spr_req,
    input  logic [AW-1:0] spr_addr,
    output logic          spr_gnt,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_dout,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [CW-1:0] rsp_color,
    output logic [7:0]    conflict_cnt
);

    logic             gnt_bg_c;
    logic             gnt_spr_c;
    logic [AW-1:0]    addr_d;
    logic [AW-1:0]    addr_q;
    logic             rsp_valid_q;
    req_id_e          rsp_id_q;
    logic [CNT_W-1:0] cnt_q;
    logic             conflict;

    pal_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .en_i      (render_en),
        .req_bg_i  (bg_req),
        .req_spr_i (spr_req),
        .gnt_bg_c  (gnt_bg_c),
        .gnt_spr_c (gnt_spr_c)
    );

    function automatic logic [AW-1:0] mirror_addr(input logic [AW-1:0] a);
`ifdef PALETTE_MIRROR_EN
        if (a[4] && (a[1:0] == 2'b00)) begin
            return a & AW'(MIRROR_MASK);
        end
`endif
        return a;
    endfunction

    // Memory address follows the granted request and otherwise holds its last value.
    always_comb begin
        addr_d = addr_q;
        if (rst) begin
            addr_d = '0;
        end else if (gnt_bg_c) begin
            addr_d = mirror_addr(bg_addr);
        end else if (gnt_spr_c) begin
            addr_d = mirror_addr(spr_addr);
        end
    end

    assign conflict = render_en & bg_req & spr_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= REQ_BG;
            cnt_q       <= '0;
        end else begin
            addr_q      <= addr_d;
            rsp_valid_q <= gnt_bg_c | gnt_spr_c;
            rsp_id_q    <= gnt_spr_c ? REQ_SPR : REQ_BG;
            if (conflict && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Reset masks the visible state immediately, dropping any response in flight.
    assign bg_gnt       = gnt_bg_c;
    assign spr_gnt      = gnt_spr_c;
    assign mem_addr     = addr_d;
    assign rsp_valid    = rsp_valid_q & ~rst;
    assign rsp_id       = rst ? 1'b0 : 1'(rsp_id_q);
    assign rsp_color    = mem_dout[CW-1:0];
    assign conflict_cnt = rst ? 8'h00 : cnt_q;

    generate
        if (CW < DW) begin : g_dout_hi
            logic unused_dout_hi;
            assign unused_dout_hi = ^mem_dout[DW-1:CW];
        end
    endgenerate

endmodule : palette_arbiter

// File: tb/tb_palette_arbiter.sv
// Directed bench for palette_arbiter; memory model returns entry k = k + 0x20 one cycle later.
module tb_palette_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       render_en;
    logic       bg_req;
    logic [4:0] bg_addr;
    logic       bg_gnt;
    logic       spr_req;
    logic [4:0] spr_addr;
    logic       spr_gnt;
    logic [4:0] mem_addr;
    logic [7:0] mem_dout = 8'h00;
    logic       rsp_valid;
    logic       rsp_id;
    logic [5:0] rsp_color;
    logic [7:0] conflict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) mem_dout <= 8'(mem_addr) + 8'h20;

    palette_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .render_en    (render_en),
        .bg_req       (bg_req),
        .bg_addr      (bg_addr),
        .bg_gnt       (bg_gnt),
        .spr_req      (spr_req),
        .spr_addr     (spr_addr),
        .spr_gnt      (spr_gnt),
        .mem_addr     (mem_addr),
        .mem_dout     (mem_dout),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_color    (rsp_color),
        .conflict_cnt (conflict_cnt)
    );

`ifdef PALETTE_MIRROR_EN
    localparam logic [4:0] A14 = 5'h04, A10 = 5'h00, A1C = 5'h0C;
    localparam logic [5:0] C14 = 6'h24, C10 = 6'h20, C1C = 6'h2C;
`else
    localparam logic [4:0] A14 = 5'h14, A10 = 5'h10, A1C = 5'h1C;
    localparam logic [5:0] C14 = 6'h34, C10 = 6'h30, C1C = 6'h3C;
`endif

    typedef struct {
        logic       rst, en, bgr;
        logic [4:0] bga;
        logic       sprr;
        logic [4:0] spra;
        logic       gb, gs;
        logic [4:0] ma;
        logic       rv, rid;
        logic [5:0] col;
        logic [7:0] cnt;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(logic r, logic e, logic br, logic [4:0] ba, logic sr, logic [4:0] sa,
                                logic gb, logic gs, logic [4:0] ma, logic rv, logic rid,
                                logic [5:0] col, logic [7:0] cnt);
        vec_t v;
        v.rst = r; v.en = e; v.bgr = br; v.bga = ba; v.sprr = sr; v.spra = sa;
        v.gb = gb; v.gs = gs; v.ma = ma; v.rv = rv; v.rid = rid; v.col = col; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic br, input logic [4:0] ba,
                         input logic sr, input logic [4:0] sa);
        rst = r; render_en = e; bg_req = br; bg_addr = ba; spr_req = sr; spr_addr = sa;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 5'h00);

        //                 rst en bgr bga   spr spa    gb gs ma    rv rid col    cnt
        vecs[0]  = mk(1, 1, 1, 5'h05, 1, 5'h11, 0, 0, 5'h00, 0, 0, 6'h00, 8'd0);
        vecs[1]  = mk(0, 1, 1, 5'h05, 0, 5'h00, 1, 0, 5'h05, 0, 0, 6'h00, 8'd0);
        vecs[2]  = mk(0, 1, 0, 5'h00, 0, 5'h00, 0, 0, 5'h05, 1, 0, 6'h25, 8'd0);
        vecs[3]  = mk(1, 1, 0, 5'h00, 0, 5'h00, 0, 0, 5'h00, 0, 0, 6'h00, 8'd0);
        vecs[4]  = mk(0, 1, 1, 5'h01, 1, 5'h11, 1, 0, 5'h01, 0, 0, 6'h00, 8'd0);
        vecs[5]  = mk(0, 1, 1, 5'h01, 1, 5'h11, 0, 1, 5'h11, 1, 0, 6'h21, 8'd1);
        vecs[6]  = mk(0, 1, 1, 5'h01, 1, 5'h11, 1, 0, 5'h01, 1, 1, 6'h31, 8'd2);
        vecs[7]  = mk(0, 1, 1, 5'h01, 1, 5'h11, 0, 1, 5'h11, 1, 0, 6'h21, 8'd3);
        vecs[8]  = mk(0, 1, 0, 5'h00, 0, 5'h00, 0, 0, 5'h11, 1, 1, 6'h31, 8'd4);
        vecs[9]  = mk(0, 0, 1, 5'h01, 1, 5'h11, 0, 0, 5'h11, 0, 0, 6'h00, 8'd4);
        vecs[10] = mk(0, 0, 1, 5'h01, 1, 5'h11, 0, 0, 5'h11, 0, 0, 6'h00, 8'd4);
        vecs[11] = mk(0, 1, 0, 5'h00, 0, 5'h00, 0, 0, 5'h11, 0, 0, 6'h00, 8'd4);
        vecs[12] = mk(0, 1, 1, 5'h02, 1, 5'h03, 1, 0, 5'h02, 0, 0, 6'h00, 8'd4);
        vecs[13] = mk(0, 1, 0, 5'h00, 1, 5'h14, 0, 1, A14,   1, 0, 6'h22, 8'd5);
        vecs[14] = mk(0, 1, 0, 5'h00, 0, 5'h00, 0, 0, A14,   1, 1, C14,   8'd5);
        vecs[15] = mk(0, 1, 0, 5'h00, 1, 5'h10, 0, 1, A10,   0, 0, 6'h00, 8'd5);
        vecs[16] = mk(0, 1, 0, 5'h00, 0, 5'h00, 0, 0, A10,   1, 1, C10,   8'd5);
        vecs[17] = mk(0, 1, 1, 5'h1C, 0, 5'h00, 1, 0, A1C,   0, 0, 6'h00, 8'd5);
        vecs[18] = mk(0, 1, 0, 5'h00, 0, 5'h00, 0, 0, A1C,   1, 0, C1C,   8'd5);
        vecs[19] = mk(0, 1, 1, 5'h07, 0, 5'h00, 1, 0, 5'h07, 0, 0, 6'h00, 8'd5);
        vecs[20] = mk(0, 1, 0, 5'h00, 0, 5'h00, 0, 0, 5'h07, 1, 0, 6'h27, 8'd5);
        vecs[21] = mk(0, 1, 1, 5'h09, 0, 5'h00, 1, 0, 5'h09, 0, 0, 6'h00, 8'd5);
        vecs[22] = mk(1, 1, 1, 5'h0A, 1, 5'h0B, 0, 0, 5'h00, 0, 0, 6'h00, 8'd0);
        vecs[23] = mk(0, 1, 1, 5'h0A, 1, 5'h0B, 1, 0, 5'h0A, 0, 0, 6'h00, 8'd0);
        vecs[24] = mk(0, 1, 0, 5'h00, 0, 5'h00, 0, 0, 5'h0A, 1, 0, 6'h2A, 8'd1);

        // Inputs change on the falling edge; everything is checked 1 ns later.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].en, vecs[i].bgr, vecs[i].bga, vecs[i].sprr, vecs[i].spra);
            #1;
            check("bg_gnt",       i, 32'(bg_gnt),       32'(vecs[i].gb));
            check("spr_gnt",      i, 32'(spr_gnt),      32'(vecs[i].gs));
            check("mem_addr",     i, 32'(mem_addr),     32'(vecs[i].ma));
            check("rsp_valid",    i, 32'(rsp_valid),    32'(vecs[i].rv));
            check("conflict_cnt", i, 32'(conflict_cnt), 32'(vecs[i].cnt));
            if (vecs[i].rv || vecs[i].rst) begin
                check("rsp_id", i, 32'(rsp_id), 32'(vecs[i].rid));
            end
            if (vecs[i].rv) begin
                check("rsp_color", i, 32'(rsp_color), 32'(vecs[i].col));
            end
        end

        // Saturation: reset, then both requesters held for 300 cycles.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 5'h00, 1'b0, 5'h00);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b1, 5'h01, 1'b1, 5'h11);
            #1;
            check("rr_bg_gnt", 100 + c, 32'(bg_gnt), 32'((c % 2) == 0));
            if (c == 100) check("cnt_mid", c, 32'(conflict_cnt), 32'd100);
            if (c == 255) check("cnt_sat", c, 32'(conflict_cnt), 32'd255);
            if (c == 299) check("cnt_hold", c, 32'(conflict_cnt), 32'd255);
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 5'h00);
        #1;
        check("cnt_final", 400, 32'(conflict_cnt), 32'd255);
        check("rsp_last", 400, 32'(rsp_valid), 32'd1);

        // Reset with a pending response and requests: nothing leaks out.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 5'h00, 1'b1, 5'h06);
        #1;
        check("spr_alone", 401, 32'(spr_gnt), 32'd1);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 5'h03, 1'b1, 5'h06);
        #1;
        check("rst_drop", 402, 32'(rsp_valid), 32'd0);
        check("rst_gnt", 402, 32'({bg_gnt, spr_gnt}), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 5'h03, 1'b1, 5'h06);
        #1;
        check("post_rst_bg", 403, 32'({bg_gnt, spr_gnt}), 32'b10);
        check("post_rst_rv", 403, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 5'h00);
        #1;
        check("post_rst_col", 404, 32'(rsp_color), 32'h23);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_palette_arbiter
